// File: rtl/neuron_update_scheduler_pkg.sv
// Shared types for the neuron update scheduler and the potential adder.
// State encoding, model codes, init_mode codes and the operand bundle.
package neuron_update_scheduler_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG       = 3'd1,
    ST_READ      = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_WRITE     = 3'd6,
    ST_FINISH    = 3'd7
  } sched_state_e;

  typedef enum logic [1:0] {
    MODEL_LIF  = 2'b00,
    MODEL_IZH  = 2'b01,
    MODEL_QLIF = 2'b10
  } model_e;

  typedef enum logic [2:0] {
    INIT_A = 3'b001,
    INIT_B = 3'b010,
    INIT_C = 3'b011,
    INIT_D = 3'b100,
    INIT_V = 3'b101,
    INIT_U = 3'b110
  } init_mode_e;

  typedef struct packed {
    word_t      weight;
    word_t      potential;
    logic [1:0] model;
  } operand_t;

endpackage

// File: rtl/neuron_update_scheduler_if.sv
// Bus between the scheduler, the state memory, the adder and the host.
// master = scheduler side, slave = environment side.
interface neuron_update_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             time_step;
  logic [1:0]       model_sel;
  logic             cfg_valid;
  logic [2:0]       cfg_mode;
  logic [31:0]      cfg_value;
  logic             cfg_ready;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_weight;
  logic [31:0]      rd_potential;
  logic             add_time_step;
  logic             add_load;
  logic [2:0]       add_init_mode;
  logic [31:0]      add_input_weight;
  logic [31:0]      add_decayed_potential;
  logic [1:0]       add_model;
  logic [31:0]      add_final_potential;
  logic             add_done;
  logic             add_spike;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_potential;
  logic             spike_valid;
  logic [IDX_W-1:0] spike_idx;
  logic             busy;
  logic             sweep_done;
  logic             timeout_err;

  modport master (
    input  time_step, model_sel,
    input  cfg_valid, cfg_mode, cfg_value,
    output cfg_ready,
    output rd_en, rd_idx,
    input  rd_weight, rd_potential,
    output add_time_step, add_load,
    output add_init_mode, add_input_weight,
    output add_decayed_potential, add_model,
    input  add_final_potential, add_done,
    input  add_spike,
    output wr_en, wr_idx, wr_potential,
    output spike_valid, spike_idx,
    output busy, sweep_done, timeout_err
  );

  modport slave (
    output time_step, model_sel,
    output cfg_valid, cfg_mode, cfg_value,
    input  cfg_ready,
    input  rd_en, rd_idx,
    output rd_weight, rd_potential,
    input  add_time_step, add_load,
    input  add_init_mode, add_input_weight,
    input  add_decayed_potential, add_model,
    output add_final_potential, add_done,
    output add_spike,
    input  wr_en, wr_idx, wr_potential,
    input  spike_valid, spike_idx,
    input  busy, sweep_done, timeout_err
  );

endinterface

// File: rtl/sched_timeout_counter.sv
// Adder wait watchdog: cleared by load, counts while enabled,
// expire is high on the LIMIT-th enabled cycle since load.
module sched_timeout_counter #(
  parameter int LIMIT = 2047
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire = enable && (cnt_q == CW'(LIMIT - 1));

  // Next count: load wins, then saturate at expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (enable && !expire)
      cnt_d = cnt_q + CW'(1);
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/neuron_update_scheduler.sv
// Sweeps every neuron once per time step through the potential adder.
// Read, capture, issue, wait, write back; registered outputs only.
module neuron_update_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT     = 2047
) (
  input logic                      clk,
  input logic                      rst,
  neuron_update_scheduler_if.master bus
);
  import neuron_update_scheduler_pkg::*;

  sched_state_e     state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [1:0]       model_q;
  operand_t         opnd_q;

  logic             rd_en_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic             add_ts_q;
  logic             add_load_q;
  logic [2:0]       add_mode_q;
  logic             wr_en_q;
  logic [IDX_W-1:0] wr_idx_q;
  word_t            wr_pot_q;
  logic             spk_v_q;
  logic [IDX_W-1:0] spk_idx_q;
  logic             busy_q;
  logic             done_q;
  logic             tmo_err_q;
  logic             cfg_rdy_q;

  logic             last_w;
  logic             tmo_load;
  logic             tmo_en;
  logic             tmo_exp;

  assign idx_d    = idx_q + IDX_W'(1);
  assign last_w   = (idx_q == IDX_W'(NUM_NEURONS - 1));
  assign tmo_load = (state_q == ST_ISSUE);
  assign tmo_en   = (state_q == ST_WAIT_DONE);

  sched_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .load   (tmo_load),
    .enable (tmo_en),
    .expire (tmo_exp)
  );

  // Sweep sequencer: state, neuron index and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      model_q    <= '0;
      opnd_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      add_ts_q   <= 1'b0;
      add_load_q <= 1'b0;
      add_mode_q <= '0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_pot_q   <= '0;
      spk_v_q    <= 1'b0;
      spk_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
      cfg_rdy_q  <= 1'b0;
    end else begin
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      add_ts_q   <= 1'b0;
      add_load_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_pot_q   <= '0;
      spk_v_q    <= 1'b0;
      spk_idx_q  <= '0;
      done_q     <= 1'b0;
      cfg_rdy_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.cfg_valid) begin
            state_q       <= ST_CFG;
            add_load_q    <= 1'b1;
            add_mode_q    <= bus.cfg_mode;
            opnd_q.weight <= bus.cfg_value;
            cfg_rdy_q     <= 1'b1;
          end else if (bus.time_step) begin
            state_q  <= ST_READ;
            idx_q    <= '0;
            model_q  <= bus.model_sel;
            busy_q   <= 1'b1;
            rd_en_q  <= 1'b1;
            rd_idx_q <= '0;
          end
        end
        ST_CFG: begin
          state_q    <= ST_IDLE;
          add_mode_q <= '0;
          opnd_q     <= '0;
        end
        ST_READ: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_q  <= ST_ISSUE;
          add_ts_q <= 1'b1;
          opnd_q   <= '{
            weight:    bus.rd_weight,
            potential: bus.rd_potential,
            model:     model_q
          };
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.add_done) begin
            state_q   <= ST_WRITE;
            opnd_q    <= '0;
            wr_en_q   <= 1'b1;
            wr_idx_q  <= idx_q;
            wr_pot_q  <= bus.add_final_potential;
            spk_v_q   <= bus.add_spike;
            spk_idx_q <= bus.add_spike ? idx_q : '0;
          end else if (tmo_exp) begin
            // Adder hung: keep the decayed value, no spike.
            state_q   <= ST_WRITE;
            opnd_q    <= '0;
            tmo_err_q <= 1'b1;
            wr_en_q   <= 1'b1;
            wr_idx_q  <= idx_q;
            wr_pot_q  <= opnd_q.potential;
          end
        end
        ST_WRITE: begin
          if (last_w) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q  <= ST_READ;
            idx_q    <= idx_d;
            rd_en_q  <= 1'b1;
            rd_idx_q <= idx_d;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready             = cfg_rdy_q;
  assign bus.rd_en                 = rd_en_q;
  assign bus.rd_idx                = rd_idx_q;
  assign bus.add_time_step         = add_ts_q;
  assign bus.add_load              = add_load_q;
  assign bus.add_init_mode         = add_mode_q;
  assign bus.add_input_weight      = opnd_q.weight;
  assign bus.add_decayed_potential = opnd_q.potential;
  assign bus.add_model             = opnd_q.model;
  assign bus.wr_en                 = wr_en_q;
  assign bus.wr_idx                = wr_idx_q;
  assign bus.wr_potential          = wr_pot_q;
  assign bus.spike_valid           = spk_v_q;
  assign bus.spike_idx             = spk_idx_q;
  assign bus.busy                  = busy_q;
  assign bus.sweep_done            = done_q;
  assign bus.timeout_err           = tmo_err_q;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Scoreboard bench for neuron_update_scheduler with an adder stub.
// Writebacks are queued at sweep start and checked by a monitor.
module tb_neuron_update_scheduler;

  localparam int N   = 16;
  localparam int IW  = 4;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  neuron_update_scheduler_if #(.IDX_W(IW)) bus();

  neuron_update_scheduler #(
    .NUM_NEURONS (N),
    .IDX_W       (IW),
    .TIMEOUT     (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] pot;
    logic        spk;
  } exp_t;

  exp_t        exp_q[$];
  int          checks     = 0;
  int          failures   = 0;
  int          exp_sweeps = 0;
  int          hang_idx   = -1;
  logic [1:0]  exp_model  = 2'b00;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  function automatic logic [31:0] wt(int i);
    return 32'd100 + 32'(i) * 32'd10;
  endfunction

  function automatic logic [31:0] pt(int i);
    return 32'd5000 + 32'(i) * 32'd3;
  endfunction

  function automatic logic spk(int i);
    return (i == 3) || (i == 9);
  endfunction

  function automatic logic [127:0] outs();
    return {bus.rd_en, bus.rd_idx, bus.add_time_step,
            bus.add_load, bus.add_init_mode,
            bus.add_input_weight,
            bus.add_decayed_potential, bus.add_model,
            bus.wr_en, bus.wr_idx, bus.wr_potential,
            bus.spike_valid, bus.spike_idx, bus.busy,
            bus.sweep_done, bus.timeout_err,
            bus.cfg_ready};
  endfunction

  task automatic push_sweep(int last);
    exp_t e;
    for (int i = 0; i <= last; i++) begin
      e.idx = i;
      if (i == hang_idx) begin
        e.pot = pt(i);
        e.spk = 1'b0;
      end else begin
        e.pot = wt(i) + pt(i);
        e.spk = spk(i);
      end
      exp_q.push_back(e);
    end
  endtask

  // Memory and adder stub: data one cycle after rd_en,
  // done three cycles after add_time_step, never for hang_idx.
  initial begin
    int   s_idx;
    int   s_cnt;
    logic pend;
    s_idx = 0;
    s_cnt = 0;
    pend  = 1'b0;
    bus.rd_weight           = '0;
    bus.rd_potential        = '0;
    bus.add_done            = 1'b0;
    bus.add_spike           = 1'b0;
    bus.add_final_potential = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.add_done            = 1'b0;
      bus.add_spike           = 1'b0;
      bus.add_final_potential = '0;
      bus.rd_weight           = 32'hDEAD_BEEF;
      bus.rd_potential        = 32'hBAD0_0BAD;
      if (rst) begin
        s_cnt = 0;
        pend  = 1'b0;
      end else begin
        if (pend) begin
          bus.rd_weight    = wt(s_idx);
          bus.rd_potential = pt(s_idx);
        end
        pend = bus.rd_en;
        if (bus.rd_en)
          s_idx = int'(bus.rd_idx);
        if (bus.add_time_step) begin
          chk("issue_weight", bus.add_input_weight, wt(s_idx));
          chk("issue_potential", bus.add_decayed_potential,
              pt(s_idx));
          chk("issue_model", bus.add_model, exp_model);
          s_cnt = (s_idx == hang_idx) ? 0 : 3;
        end else if (s_cnt > 0) begin
          s_cnt--;
          if (s_cnt == 0) begin
            bus.add_done            = 1'b1;
            bus.add_final_potential = wt(s_idx) + pt(s_idx);
            bus.add_spike           = spk(s_idx);
          end
        end
      end
    end
  end

  // Monitor: pops one expectation per wr_en, tracks sweep_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.wr_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_wr", {1'b1, bus.wr_idx}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("wr_idx", bus.wr_idx, e.idx);
            chk("wr_potential", bus.wr_potential, e.pot);
            chk("spike_valid", bus.spike_valid, e.spk);
            chk("spike_idx", bus.spike_idx,
                e.spk ? e.idx : 0);
          end
        end else if (bus.spike_valid) begin
          chk("spike_without_wr", bus.spike_valid, 0);
        end
        if (bus.sweep_done) begin
          if (exp_sweeps == 0) begin
            chk("unexpected_sweep_done", bus.sweep_done, 0);
          end else begin
            chk("sweep_done_after_all_wr", exp_q.size(), 0);
            exp_sweeps--;
          end
        end
      end
    end
  end

  task automatic wait_sweep(string name, int budget);
    int n;
    n = 0;
    while (exp_sweeps != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_sweeps, 0);
  endtask

  task automatic pulse_ts();
    bus.time_step = 1'b1;
    @(negedge clk);
    bus.time_step = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    int n;
    int ridx;
    bus.time_step = 1'b0;
    bus.model_sel = 2'b00;
    bus.cfg_valid = 1'b0;
    bus.cfg_mode  = 3'b000;
    bus.cfg_value = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", outs(), 0);

    // Config load while idle.
    bus.cfg_mode  = 3'b101;
    bus.cfg_value = 32'd50;
    bus.cfg_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cfg_ready && n < 5);
    chk("cfg_ready", bus.cfg_ready, 1);
    chk("cfg_add_load", bus.add_load, 1);
    chk("cfg_init_mode", bus.add_init_mode, 3'b101);
    chk("cfg_value", bus.add_input_weight, 50);
    chk("cfg_not_busy", bus.busy, 0);
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("cfg_one_cycle", {bus.add_load, bus.cfg_ready}, 0);

    // Sweep 1: clean adder, spikes on 3 and 9.
    hang_idx  = -1;
    exp_model = 2'b10;
    bus.model_sel = 2'b10;
    push_sweep(N - 1);
    exp_sweeps = 1;
    pulse_ts();
    chk("sweep1_start", {bus.busy, bus.rd_en, bus.rd_idx},
        {1'b1, 1'b1, 4'd0});
    wait_sweep("sweep1_done", 400);
    chk("sweep1_no_timeout", bus.timeout_err, 0);
    @(negedge clk);
    chk("sweep1_idle", bus.busy, 0);

    // Sweep 2: idx 5 hangs; time_step and cfg mid-sweep.
    hang_idx  = 5;
    exp_model = 2'b01;
    bus.model_sel = 2'b01;
    push_sweep(N - 1);
    exp_sweeps = 1;
    pulse_ts();
    repeat (10) @(negedge clk);
    bus.model_sel = 2'b10;
    bus.cfg_mode  = 3'b011;
    bus.cfg_value = 32'd77;
    bus.cfg_valid = 1'b1;
    pulse_ts();
    n = 0;
    while (!bus.cfg_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("busy_cfg_accepted", bus.cfg_ready, 1);
    chk("busy_cfg_after_sweep", exp_sweeps, 0);
    chk("busy_cfg_all_wr", exp_q.size(), 0);
    chk("busy_cfg_not_busy", bus.busy, 0);
    chk("busy_cfg_fields",
        {bus.add_load, bus.add_init_mode, bus.add_input_weight},
        {1'b1, 3'b011, 32'd77});
    chk("timeout_err_set", bus.timeout_err, 1);
    bus.cfg_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_restart", bus.busy, 0);

    // cfg_valid beats time_step in the same cycle.
    bus.model_sel = 2'b00;
    bus.cfg_mode  = 3'b001;
    bus.cfg_value = 32'd9;
    bus.cfg_valid = 1'b1;
    pulse_ts();
    chk("prio_cfg_ready", bus.cfg_ready, 1);
    chk("prio_cfg_mode", bus.add_init_mode, 3'b001);
    bus.cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("prio_ts_dropped", bus.busy, 0);

    // Sweep 3: reset during WAIT_DONE of idx 7.
    hang_idx  = -1;
    exp_model = 2'b00;
    push_sweep(6);
    pulse_ts();
    ridx = -1;
    n = 0;
    while (n < 200) begin
      if (bus.rd_en)
        ridx = int'(bus.rd_idx);
      if (bus.add_time_step && ridx == 7)
        break;
      @(negedge clk);
      n++;
    end
    chk("reach_idx7_issue", {bus.add_time_step, 4'(ridx)},
        {1'b1, 4'd7});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midsweep_reset_outputs", outs(), 0);
    chk("midsweep_reset_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midsweep_all_wr_seen", exp_q.size(), 0);
    chk("midsweep_stays_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_update_scheduler.md
NEURON_UPDATE_SCHEDULER -- requirements
Module: neuron_update_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 16, number of neurons swept per time step (2..256).
REQ-002 Parameter IDX_W, default 4, neuron index width, equal to clog2(NUM_NEURONS).
REQ-003 Parameter TIMEOUT, default 2047, maximum cycles to wait for adder done.
REQ-004 Ports, given as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- time_step  in  1  one-cycle pulse that starts a sweep.
- model_sel  in  2  neuron model (00 LIF, 01 Izhikevich, 10 QLIF); sampled at sweep start.
- cfg_valid  in  1  parameter-load request.
- cfg_mode  in  3  init_mode code (001..110).
- cfg_value  in  32  parameter value.
- cfg_ready  out  1  config accepted this cycle.
- rd_en  out  1  neuron state read strobe.
- rd_idx  out  IDX_W  neuron state read index.
- rd_weight  in  32  accumulated input weight, valid the cycle after rd_en.
- rd_potential  in  32  decayed potential, valid the cycle after rd_en.
- add_time_step  out  1  adder start pulse.
- add_load  out  1  adder parameter load.
- add_init_mode  out  3  adder init_mode.
- add_input_weight  out  32  adder input_weight or cfg_value.
- add_decayed_potential  out  32  adder decayed_potential.
- add_model  out  2  adder model.
- add_final_potential  in  32  adder result.
- add_done  in  1  adder completion.
- add_spike  in  1  adder spike flag.
- wr_en  out  1  potential writeback strobe.
- wr_idx  out  IDX_W  writeback index.
- wr_potential  out  32  writeback value.
- spike_valid  out  1  spike event strobe.
- spike_idx  out  IDX_W  spiking neuron index.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at sweep end.
- timeout_err  out  1  sticky adder-timeout flag.

Function
REQ-005 FSM states: IDLE, CFG, READ, CAPTURE, ISSUE, WAIT_DONE, WRITE, FINISH.
REQ-006 IDLE: cfg_valid has priority over time_step; cfg_valid moves to CFG, otherwise time_step moves to READ with idx=0 and model_sel latched.
REQ-007 CFG, one cycle: add_load=1, add_init_mode=cfg_mode, add_input_weight=cfg_value, cfg_ready=1, then return to IDLE.
REQ-008 cfg_valid while busy is held off with cfg_ready=0; time_step while busy is ignored and dropped.
REQ-009 READ: rd_en=1, rd_idx=idx for one cycle, then CAPTURE.
REQ-010 CAPTURE registers rd_weight and rd_potential, then ISSUE.
REQ-011 ISSUE: add_time_step=1 for exactly one cycle, with the registered operands and latched model held stable on add_* from ISSUE until leaving WAIT_DONE.
REQ-012 WAIT_DONE exits on add_done=1 to WRITE, latching add_final_potential and add_spike that same cycle.
REQ-013 If the wait counter reaches TIMEOUT in WAIT_DONE: set timeout_err, write back the unchanged decayed potential with no spike, and continue the sweep.
REQ-014 WRITE, one cycle: wr_en=1, wr_idx=idx, wr_potential=latched result; spike_valid=1 and spike_idx=idx in the same cycle if the latched spike is set.
REQ-015 After WRITE: if idx==NUM_NEURONS-1 go to FINISH, otherwise increment idx and go to READ; idx never wraps mid-sweep.
REQ-016 FINISH: sweep_done=1 for one cycle, then IDLE.
REQ-017 busy=1 in every state except IDLE and CFG.
REQ-018 Per-neuron latency is 5 cycles plus the adder latency; the zero-latency floor is add_done asserted the cycle after ISSUE.
REQ-019 All strobe outputs are registered, glitch-free, and 0 outside their defined states.
REQ-020 add_done arriving outside WAIT_DONE is ignored.

Reset
REQ-021 While rst=1 at a clock edge, the FSM goes to IDLE, idx and the wait counter clear, and all outputs are 0, including timeout_err.
REQ-022 Reset mid-sweep abandons the sweep with no further wr_en, spike_valid or sweep_done; adder state is not this block's concern.

Structure
REQ-023 A shared package holds the state encoding, the model codes (LIF/IZH/QLIF) and the init_mode codes (A=001..U=110), shared with potential_adder.
REQ-024 One sub-module, sched_timeout_counter (load, enable, expire), is natural; everything else is flat.

Verification
REQ-025 Reset, then time_step with an adder stub (done after 3 cycles, final=weight+potential): 16 wr_en pulses with idx 0..15 in order, then one sweep_done.
REQ-026 cfg_valid with cfg_mode=101 and cfg_value=50 while idle: one-cycle add_load with add_init_mode=101 and add_input_weight=50, cfg_ready=1.
REQ-027 Stub spikes on idx 3 and 9: spike_valid pulses carry spike_idx=3 and 9, each coincident with its wr_en.
REQ-028 Stub never asserts done for idx 5 with TIMEOUT=20: timeout_err=1, wr_potential for idx 5 equals rd_potential, and the sweep completes.
REQ-029 time_step during a sweep and cfg_valid during a sweep: no restart, cfg_ready=0 until IDLE, then config accepted.
REQ-030 rst asserted during WAIT_DONE of idx 7: next cycle busy=0 and all outputs 0; no sweep_done follows.
